// File: rtl/qsn_pipe.sv
// qsn_pipe: two-stage valid/ready cyclic-shift network (QSN) for LDPC lifting.
// Optional QSN_PIPE_REVERSE_EN adds in_dir for backward rotation.
module qsn_pipe #(
    parameter  int Z_MAX = 8,
    parameter  int W     = 4,
    localparam int SW    = $clog2(Z_MAX),
    localparam int ZW    = SW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Z_MAX*W-1:0]   in_data,
    input  logic [SW-1:0]        in_shift,
    input  logic [ZW-1:0]        in_z,
`ifdef QSN_PIPE_REVERSE_EN
    input  logic                 in_dir,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Z_MAX*W-1:0]   out_data,
    output logic                 out_err
);
    localparam int DW = Z_MAX * W;

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic [SW-1:0] s1_shift_q, s1_shift_d;
    logic [ZW-1:0] s1_z_q, s1_z_d;
    logic          s1_err_q, s1_err_d;
    logic          s1_dir_q, s1_dir_d;

    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic          s2_err_q, s2_err_d;

    logic          s2_adv;
    logic          in_err;
    logic          dir_in;
    logic [ZW-1:0] eff_sh;
    logic [ZW-1:0] wrap_sh;
    logic [DW-1:0] rot_a, rot_b, rot_out;

`ifdef QSN_PIPE_REVERSE_EN
    assign dir_in = in_dir;
`else
    assign dir_in = 1'b0;
`endif

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    assign in_err = (in_z == '0) || (in_z > ZW'(Z_MAX))
                 || ({1'b0, in_shift} >= in_z);

    // Illegal beats pass through unrotated, clamped to the word width.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_shift_d = s1_shift_q;
        s1_z_d     = s1_z_q;
        s1_err_d   = s1_err_q;
        s1_dir_d   = s1_dir_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d  = in_data;
                s1_err_d   = in_err;
                s1_z_d     = (in_z > ZW'(Z_MAX)) ? ZW'(Z_MAX) : in_z;
                s1_shift_d = in_err ? '0 : in_shift;
                s1_dir_d   = dir_in;
            end
        end
    end

    // Backward rotation by s equals forward rotation by z - s.
    always_comb begin
        eff_sh = {1'b0, s1_shift_q};
        if (s1_dir_q && (s1_shift_q != '0)) begin
            eff_sh = s1_z_q - {1'b0, s1_shift_q};
        end
        wrap_sh = s1_z_q - eff_sh;
    end

    always_comb begin
        rot_a = s1_data_q;
        rot_b = s1_data_q;
        for (int k = 0; k < ZW; k++) begin
            if (eff_sh[k]) rot_a = rot_a >> (W * (1 << k));
            if (wrap_sh[k]) rot_b = rot_b << (W * (1 << k));
        end
        rot_out = '0;
        for (int i = 0; i < Z_MAX; i++) begin
            if (i < int'(s1_z_q)) begin
                if (i + int'(eff_sh) < int'(s1_z_q)) begin
                    rot_out[i*W +: W] = rot_a[i*W +: W];
                end else begin
                    rot_out[i*W +: W] = rot_b[i*W +: W];
                end
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_err_d   = s2_err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = rot_out;
                s2_err_d  = s1_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_shift_q <= '0;
            s1_z_q     <= '0;
            s1_err_q   <= 1'b0;
            s1_dir_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_shift_q <= s1_shift_d;
            s1_z_q     <= s1_z_d;
            s1_err_q   <= s1_err_d;
            s1_dir_q   <= s1_dir_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_qsn_pipe.sv
// tb_qsn_pipe: directed vector table plus backpressure and reset sequences.
// Build with QSN_PIPE_REVERSE_EN to also exercise backward rotation.
module tb_qsn_pipe;
    localparam int Z_MAX = 8;
    localparam int W     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_shift;
    logic [3:0]  in_z;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    qsn_pipe #(.Z_MAX(Z_MAX), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_z      (in_z),
`ifdef QSN_PIPE_REVERSE_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [2:0]  sh;
        logic [3:0]  z;
        logic        dir;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v.data;
        in_shift = v.sh;
        in_z     = v.z;
        in_dir   = v.dir;
        #1;
        chk($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk($sformatf("vec%0d early_valid", idx), 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d out_data", idx), out_data, v.exp);
        chk($sformatf("vec%0d out_err", idx), 32'(out_err), 32'(v.err));
    endtask

    function automatic logic [31:0] tag(input int k);
        return 32'h11111111 * (k + 1);
    endfunction

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] held;
        logic        was_stalled;
        int sent;
        int got;

        vecs.push_back('{32'h76543210, 3'd3, 4'd8, 1'b0, 32'h21076543, 1'b0});
        vecs.push_back('{32'h87654321, 3'd2, 4'd5, 1'b0, 32'h00021543, 1'b0});
        vecs.push_back('{32'h87654321, 3'd6, 4'd5, 1'b0, 32'h00054321, 1'b1});
        vecs.push_back('{32'h87654321, 3'd5, 4'd5, 1'b0, 32'h00054321, 1'b1});
        vecs.push_back('{32'h87654321, 3'd0, 4'd0, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{32'h87654321, 3'd1, 4'd9, 1'b0, 32'h87654321, 1'b1});
        vecs.push_back('{32'h76543210, 3'd0, 4'd8, 1'b0, 32'h76543210, 1'b0});
        vecs.push_back('{32'h76543210, 3'd7, 4'd8, 1'b0, 32'h65432107, 1'b0});
        vecs.push_back('{32'h87654321, 3'd0, 4'd1, 1'b0, 32'h00000001, 1'b0});
        vecs.push_back('{32'h87654321, 3'd1, 4'd2, 1'b0, 32'h00000012, 1'b0});
`ifdef QSN_PIPE_REVERSE_EN
        vecs.push_back('{32'h76543210, 3'd3, 4'd8, 1'b1, 32'h43210765, 1'b0});
        vecs.push_back('{32'h87654321, 3'd2, 4'd5, 1'b1, 32'h00032154, 1'b0});
        vecs.push_back('{32'h87654321, 3'd6, 4'd5, 1'b1, 32'h00054321, 1'b1});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_z      = '0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Backpressure: four beats, out_ready low for the first three cycles.
        @(negedge clk);
        sent = 0;
        got  = 0;
        was_stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (sent < 4);
            in_data   = tag(sent);
            in_shift  = 3'd0;
            in_z      = 4'd8;
            in_dir    = 1'b0;
            #1;
            if (cyc == 2) chk("bp in_ready_drop", 32'(in_ready), 32'd0);
            if (was_stalled) chk("bp hold_data", out_data, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp spurious_beat", 32'(got), 32'hffffffff);
                end else begin
                    chk($sformatf("bp beat%0d", got), out_data, exp_q.pop_front());
                end
                got++;
            end
            was_stalled = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(tag(sent));
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp delivered", 32'(got), 32'd4);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp no_dup", 32'(out_valid), 32'd0);
        end

        // Mid-operation reset with both stages full.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = tag(8 + k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("mr full in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr out_valid", 32'(out_valid), 32'd0);
        chk("mr in_ready", 32'(in_ready), 32'd1);
        chk("mr out_data", out_data, 32'd0);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("mr no_stale", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
